goldschmidt_mant_divider: RTL and testbench

Iterative Goldschmidt mantissa divider: the responder on the start/ready handshake that the floating-point division wrapper drives. It accepts two normalized mantissas with the hidden bit included, scales them into the convergence range, and runs a fixed number of multiply iterations. It then returns a rounded fixed-point quotient with a one-cycle `ready` pulse. Sign and exponent handling stay in the wrapper.

---
 rtl/goldschmidt_mant_divider.sv | 125 ++++++++++++
 tb/tb_goldschmidt_mant_divider.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/goldschmidt_mant_divider.sv
// goldschmidt_mant_divider
//   Iterative Goldschmidt divider for normalized floating-point mantissas.
//   Both operands are pre-scaled by 1/2 so the divisor lands in [0.5,1).
//   ITERS multiply steps then drive it towards 1 while the dividend
//   converges to the quotient. The result is rounded half-up and
//   returned with a single-cycle ready pulse.
//
// Ports
//   clk    : clock, rising edge
//   clrn   : asynchronous active-low reset
//   start  : request, sampled only while idle
//   a, b   : dividend / divisor mantissas 1.M (bit M is the hidden one)
//   q      : quotient a/b, 1 integer bit + M+1 fraction bits
//   ready  : one-cycle pulse, q and dz valid from this cycle
//   busy   : high while an operation is in flight
//   dz     : divisor had no hidden bit (zero/denormal), q forced to all ones
module goldschmidt_mant_divider #(
  parameter int M     = 23,
  parameter int G     = 8,
  parameter int ITERS = 5
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         start,
  input  logic [M:0]   a,
  input  logic [M:0]   b,
  output logic [M+1:0] q,
  output logic         ready,
  output logic         busy,
  output logic         dz
);

  localparam int W  = M + 2 + G;          // Q1.(M+1+G) working width
  localparam int FB = M + 1 + G;          // working fraction bits
  localparam int CW = $clog2(ITERS) + 1;

  localparam logic [W-1:0]  ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);
  // Half an output ulp, i.e. a one at bit G-1 of the working format.
  localparam logic [W:0]    HALF     = {{(W+1-G){1'b0}}, 1'b1, {(G-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  n_r, d_r;
  logic [CW-1:0] cnt;
  logic          dz_pend;

  logic [W-1:0]  f;
  logic [W-1:0]  n_mul, d_mul;
  logic [M+2:0]  q_rnd;

  // F = 2 - D is the two's complement of D modulo 2^W (2.0 is exactly 2^W).
  always_comb begin
    f     = ~d_r + ONE_W;
    n_mul = W'(({{W{1'b0}}, n_r} * {{W{1'b0}}, f}) >> FB);
    d_mul = W'(({{W{1'b0}}, d_r} * {{W{1'b0}}, f}) >> FB);
    q_rnd = (M+3)'(({1'b0, n_r} + HALF) >> G);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = b[M] ? RUN : DONE;
      RUN:     if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      n_r     <= '0;
      d_r     <= '0;
      cnt     <= '0;
      dz_pend <= 1'b0;
      q       <= '0;
      ready   <= 1'b0;
      dz      <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (b[M]) begin
              // a/2 and b/2 are exact: the operand bits sit one place lower.
              n_r     <= {1'b0, a, {G{1'b0}}};
              d_r     <= {1'b0, b, {G{1'b0}}};
              cnt     <= '0;
              dz_pend <= 1'b0;
            end else begin
              dz_pend <= 1'b1;
            end
          end
        end
        RUN: begin
          n_r <= n_mul;
          d_r <= d_mul;
          cnt <= cnt + CNT_ONE;
        end
        DONE: begin
          ready <= 1'b1;
          if (dz_pend) begin
            q  <= '1;
            dz <= 1'b1;
          end else begin
            // Top bit of the rounded value set means the result reached 2.0.
            q  <= q_rnd[M+2] ? '1 : q_rnd[M+1:0];
            dz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_goldschmidt_mant_divider.sv
// Bench for goldschmidt_mant_divider: stimulus pushes the reference result
// (ideal rounded quotient from integer arithmetic) together with the cycle
// where ready must appear; an independent monitor pops and compares.
module tb_goldschmidt_mant_divider;

  localparam int M     = 23;
  localparam int G     = 8;
  localparam int ITERS = 5;

  logic         clk   = 1'b0;
  logic         clrn  = 1'b0;
  logic         start = 1'b0;
  logic [M:0]   a     = '0;
  logic [M:0]   b     = '0;
  logic [M+1:0] q;
  logic         ready;
  logic         busy;
  logic         dz;

  goldschmidt_mant_divider #(.M(M), .G(G), .ITERS(ITERS)) dut (
    .clk   (clk),
    .clrn  (clrn),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .ready (ready),
    .busy  (busy),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [M+1:0] q;
    logic         dz;
    bit           exact;
    int unsigned  start_cyc;
    int unsigned  exp_cyc;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req, input bit ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Ideal quotient a*2^(M+1)/b rounded half-up, saturated below 2.0.
  function automatic exp_t model(input logic [M:0] aa, input logic [M:0] bb,
                                 input bit force_exact);
    exp_t e;
    longint unsigned num, den, quo, lim;
    e.start_cyc = 0;
    e.exp_cyc   = 0;
    if (!bb[M]) begin
      e.q     = '1;
      e.dz    = 1'b1;
      e.exact = 1'b1;
    end else begin
      num = 64'(aa) << (M + 1);
      den = 64'(bb);
      quo = (2 * num + den) / (2 * den);
      lim = 64'(1) << (M + 2);
      if (quo >= lim) quo = lim - 1;
      e.q     = quo[M+1:0];
      e.dz    = 1'b0;
      e.exact = force_exact || ((num % den) == 0);
    end
    return e;
  endfunction

  // Monitor: compares every ready against the scoreboard, and busy elsewhere.
  initial begin : monitor
    exp_t e;
    logic [M+1:0] diff;
    bit exp_busy;
    forever begin
      @(negedge clk);
      if (ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", {63'd0, ready}, 64'd0, 1'b0);
        end else begin
          e = sb.pop_front();
          check("ready_cycle", 64'(cyc), 64'(e.exp_cyc), cyc == e.exp_cyc);
          check("dz", {63'd0, dz}, {63'd0, e.dz}, dz == e.dz);
          diff = (q >= e.q) ? q - e.q : e.q - q;
          if (e.exact) check("q_exact", 64'(q), 64'(e.q), q == e.q);
          else         check("q_1ulp", 64'(q), 64'(e.q), diff <= 1);
        end
      end else begin
        if (sb.size() > 0 && cyc >= sb[0].exp_cyc) begin
          e = sb.pop_front();
          check("missing_ready", 64'(cyc), 64'(e.exp_cyc), 1'b0);
        end
        exp_busy = (sb.size() > 0) && (cyc >= sb[0].start_cyc) && (cyc < sb[0].exp_cyc);
        check("busy", {63'd0, busy}, {63'd0, exp_busy}, busy == exp_busy);
      end
    end
  end

  // Called just after a falling edge: start is sampled on the next rising edge.
  task automatic launch(input logic [M:0] aa, input logic [M:0] bb, input bit fx);
    exp_t e;
    a     = aa;
    b     = bb;
    start = 1'b1;
    e = model(aa, bb, fx);
    e.start_cyc = cyc + 1;
    e.exp_cyc   = cyc + 1 + (bb[M] ? ITERS + 1 : 1);
    sb.push_back(e);
  endtask

  task automatic issue(input logic [M:0] aa, input logic [M:0] bb, input bit fx);
    launch(aa, bb, fx);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0, 1'b0);
      sb.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_q"},     64'(q),           64'd0, q == '0);
    check({tag, "_ready"}, {63'd0, ready},   64'd0, ready == 1'b0);
    check({tag, "_busy"},  {63'd0, busy},    64'd0, busy == 1'b0);
    check({tag, "_dz"},    {63'd0, dz},      64'd0, dz == 1'b0);
  endtask

  initial begin : driver
    logic [31:0] r1, r2;
    int unsigned first_exp;
    clrn = 1'b0;
    #1;
    check_zero_outputs("reset_async");
    repeat (2) @(negedge clk);
    check_zero_outputs("reset_hold");
    clrn = 1'b1;
    @(negedge clk);

    // Directed cases.
    issue(24'h800000, 24'h800000, 1'b1); wait_idle();   // 1.0
    issue(24'hC00000, 24'h800000, 1'b1); wait_idle();   // 1.5
    issue(24'h800000, 24'hC00000, 1'b1); wait_idle();   // 2/3 -> 0xAAAAAB
    issue(24'h800000, 24'h000000, 1'b1); wait_idle();   // divide by zero
    issue(24'hFFFFFF, 24'h800000, 1'b1); wait_idle();   // clears dz, near 2.0
    issue(24'h800000, 24'hFFFFFF, 1'b1); wait_idle();   // near 0.5

    // Start pulsed during RUN (sampled at E2) must be ignored.
    issue(24'hA00000, 24'h900000, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();

    // Start held through the ready cycle launches a second divide.
    launch(24'hE00000, 24'hB00000, 1'b0);
    first_exp = cyc + 1 + ITERS + 1;
    for (int n = 0; n < 20 && cyc < first_exp; n++) @(negedge clk);
    launch(24'h9C0000, 24'hF10000, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset in the middle of RUN aborts without a ready.
    issue(24'hC00000, 24'hA00000, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    clrn = 1'b0;
    sb.delete();
    #1;
    check_zero_outputs("reset_midrun");
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    issue(24'hFFFFFF, 24'hFFFFFF, 1'b1); wait_idle();

    // Random normalized pairs, with occasional unnormalized divisors.
    for (int i = 0; i < 3000; i++) begin
      r1 = $urandom();
      r2 = $urandom();
      if (i % 50 == 7) issue({1'b1, r1[M-1:0]}, {1'b0, r2[M-1:0]}, 1'b0);
      else             issue({1'b1, r1[M-1:0]}, {1'b1, r2[M-1:0]}, 1'b0);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
